clk_tick_gen: RTL

Multi-channel, run-time programmable clock-enable generator replacing fixed single-divisor clock division in the fproject top level. Each channel produces a one-cycle `tick` strobe and a glitch-free square wave `sq` from the 50 MHz board clock. Divisors are reprogrammed through a shadow register that is applied at a period boundary. Downstream logic such as motor stepping, display refresh and 1 s timers consumes the ticks as enables, never as clocks.

---
 rtl/clk_tick_gen_pkg.sv | 19 +
 rtl/clk_tick_ch.sv | 65 ++++++
 rtl/clk_tick_gen.sv | 48 ++++
 3 files changed

// File: rtl/clk_tick_gen_pkg.sv
// rtl/clk_tick_gen_pkg.sv - shared clock constants and width helpers for clk_tick_gen
package clk_tick_gen_pkg;

    localparam int CLK_HZ      = 50_000_000;
    // 2 s period at the board clock: 1 s high, 1 s low
    localparam int CLK_DEF_DIV = 2 * CLK_HZ;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/clk_tick_ch.sv
// rtl/clk_tick_ch.sv - one tick/square-wave channel with a shadowed divisor
module clk_tick_ch
    import clk_tick_gen_pkg::*;
#(
    parameter int DIV_W   = 27,
    parameter int DEF_DIV = CLK_DEF_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             we,
    input  logic [DIV_W-1:0] wdata,
    output logic             pend,
    output logic             tick,
    output logic             sq
);

    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEF_DIV);

    logic [DIV_W-1:0] div_q, shd_q, cnt_q;
    logic [DIV_W-1:0] div_d, shd_d, cnt_d;
    logic             run_q, run_d, pend_d;
    logic             halt, wrap, apply;
    logic [DIV_W:0]   half;

    // cnt_q is the period position shown on tick/sq one cycle later
    always_comb begin
        shd_d  = we ? wdata : shd_q;
        halt   = !en || (div_q == '0);
        wrap   = (div_q != '0) && (cnt_q == div_q - ONE);
        apply  = halt || sync || wrap;
        div_d  = apply ? shd_d : div_q;
        pend_d = !apply && (pend || we);
        run_d  = 1'b0;
        cnt_d  = '0;
        if (!halt && (div_d != '0)) begin
            run_d = 1'b1;
            cnt_d = (sync || wrap || !run_q) ? '0 : cnt_q + ONE;
        end
        half = ({1'b0, div_q} + (DIV_W+1)'(1)) >> 1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= RST_DIV;
            shd_q <= RST_DIV;
            cnt_q <= '0;
            run_q <= 1'b0;
            pend  <= 1'b0;
            tick  <= 1'b0;
            sq    <= 1'b0;
        end else begin
            div_q <= div_d;
            shd_q <= shd_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
            pend  <= pend_d;
            tick  <= run_q && (cnt_q == div_q - ONE);
            sq    <= run_q && ({1'b0, cnt_q} < half);
        end
    end

endmodule

// File: rtl/clk_tick_gen.sv
// rtl/clk_tick_gen.sv - multi-channel programmable clock-enable generator
module clk_tick_gen
    import clk_tick_gen_pkg::*;
#(
    parameter int  N_CH    = 2,
    parameter int  DIV_W   = 27,
    parameter int  DEF_DIV = CLK_DEF_DIV,
    localparam int CH_W    = sel_width(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  en,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    output logic [N_CH-1:0]  cfg_pend,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  sq
);

    logic [N_CH-1:0] ch_we;

    // selects beyond the last channel match nothing and are dropped
    always_comb begin
        ch_we = '0;
        for (int i = 0; i < N_CH; i++)
            ch_we[i] = cfg_we && (int'(cfg_ch) == i);
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        clk_tick_ch #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .en    (en[i]),
            .sync  (sync),
            .we    (ch_we[i]),
            .wdata (cfg_div),
            .pend  (cfg_pend[i]),
            .tick  (tick[i]),
            .sq    (sq[i])
        );
    end

endmodule
